// File: rtl/grid_nav_ctrl.sv
// grid_nav_ctrl: grid cursor with auto-repeat navigation and a single-entry select handshake
// Ports: clk/rst (sync, active-high); lock freezes movement; dir_up/down/left/right and sel are
// debounced level buttons; sel_ready accepts sel_val; pos_x/pos_y/val give the cursor;
// sel_valid/sel_val hold a captured selection; sel_drop pulses when a press is lost.
module grid_nav_ctrl #(
  parameter int COLS = 6,
  parameter int ROWS = 4,
  parameter int WRAP = 1,
  parameter int RPT_DELAY = 25_000_000,
  parameter int RPT_RATE = 5_000_000,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int VW = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lock,
  input  logic          dir_up,
  input  logic          dir_down,
  input  logic          dir_left,
  input  logic          dir_right,
  input  logic          sel,
  input  logic          sel_ready,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [VW-1:0] val,
  output logic          sel_valid,
  output logic [VW-1:0] sel_val,
  output logic          sel_drop
);
  localparam int MC = RPT_DELAY > RPT_RATE ? RPT_DELAY : RPT_RATE;
  localparam int CW = $clog2(MC + 1);
  localparam logic [XW-1:0] XM = XW'(COLS - 1);
  localparam logic [YW-1:0] YM = YW'(ROWS - 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [3:0] dir, dir_q, ndir;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic go, step, armed, sel_q, sel_arm, press, xfer;
  assign dir = {dir_up, dir_down, dir_left, dir_right};
  // armed stays low after reset until every direction button has been seen released
  assign go = $onehot(dir) && armed && !lock;
  assign val = VW'(pos_y) * VW'(COLS) + VW'(pos_x);
  // sel_arm blocks a button held through reset from counting as a press
  assign press = sel && !sel_q && sel_arm;
  assign xfer = sel_valid && sel_ready;
  always_comb begin
    nstate = state;
    ncnt = cnt;
    ndir = dir_q;
    step = 1'b0;
    if (!go) begin
      nstate = IDLE;
      ncnt = '0;
    end else if (state == IDLE) begin
      step = 1'b1;
      ncnt = '0;
      ndir = dir;
      nstate = HOLD;
    end else if (dir != dir_q) begin
      nstate = IDLE;
      ncnt = '0;
    end else if (state == HOLD) begin
      step = cnt == CW'(RPT_DELAY - 1);
      ncnt = step ? '0 : cnt + CW'(1);
      nstate = step ? REPEAT : HOLD;
    end else begin
      step = cnt == CW'(RPT_RATE - 1);
      ncnt = step ? '0 : cnt + CW'(1);
    end
  end
  always_comb begin
    nx = pos_x;
    ny = pos_y;
    if (step && dir[3]) ny = pos_y == '0 ? (WRAP != 0 ? YM : pos_y) : pos_y - YW'(1);
    if (step && dir[2]) ny = pos_y == YM ? (WRAP != 0 ? '0 : pos_y) : pos_y + YW'(1);
    if (step && dir[1]) nx = pos_x == '0 ? (WRAP != 0 ? XM : pos_x) : pos_x - XW'(1);
    if (step && dir[0]) nx = pos_x == XM ? (WRAP != 0 ? '0 : pos_x) : pos_x + XW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dir_q <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      dir_q <= ndir;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
      armed <= 1'b0;
      sel_q <= 1'b0;
      sel_arm <= 1'b0;
      sel_valid <= 1'b0;
      sel_val <= '0;
      sel_drop <= 1'b0;
    end else begin
      pos_x <= nx;
      pos_y <= ny;
      armed <= armed | ~|dir;
      sel_q <= sel;
      sel_arm <= sel_arm | ~sel;
      sel_drop <= press && sel_valid && !xfer;
      if (press && (!sel_valid || xfer)) begin
        sel_val <= val;
        sel_valid <= 1'b1;
      end else if (xfer) begin
        sel_valid <= 1'b0;
      end
    end
  end
endmodule
